// File: rtl/status_hazard_pkg.sv
// Shared definitions for the rstatus (r30) hazard logic: opcode encodings,
// mult/div ALU ops and the scoreboard entry layout.
package status_hazard_pkg;

    localparam logic [4:0] OPC_ALU   = 5'b00000;
    localparam logic [4:0] OPC_ADDI  = 5'b00101;
    localparam logic [4:0] OPC_LW    = 5'b01000;
    localparam logic [4:0] OPC_SETX  = 5'b10101;
    localparam logic [4:0] OPC_BEX   = 5'b10110;

    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

    localparam int STATUS_REG_DEFAULT = 30;

    typedef struct packed {
        logic valid;
        logic is_load;
        logic is_md;
    } sb_entry_t;

    localparam int SB_ENTRY_W = $bits(sb_entry_t);

endpackage

// File: rtl/status_hazard_unit_classify.sv
// Decode-stage classification of an instruction as an rstatus writer,
// flagging loads and mult/div so later hazard checks know when data is late.
module status_writer_classify
    import status_hazard_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int STATUS_REG = STATUS_REG_DEFAULT
) (
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] opcode_i,
    input  logic [ADDR_W-1:0] aluop_i,
    input  logic [ADDR_W-1:0] rd_i,
    output sb_entry_t         entry_o
);

    logic isSetx;
    logic isAlu;
    logic isAddi;
    logic isLoad;
    logic isMulDiv;
    logic rdIsStatus;
    logic writer;

    assign isSetx     = (opcode_i == ADDR_W'(OPC_SETX));
    assign isAlu      = (opcode_i == ADDR_W'(OPC_ALU));
    assign isAddi     = (opcode_i == ADDR_W'(OPC_ADDI));
    assign isLoad     = (opcode_i == ADDR_W'(OPC_LW));
    assign isMulDiv   = (aluop_i == ADDR_W'(ALUOP_MUL)) || (aluop_i == ADDR_W'(ALUOP_DIV));
    assign rdIsStatus = (rd_i == ADDR_W'(STATUS_REG));

    // setx writes r30 implicitly; everything else must name r30 as rd
    assign writer = valid_i && (isSetx || (rdIsStatus && (isAlu || isAddi || isLoad)));

    always_comb begin
        entry_o         = '0;
        entry_o.valid   = writer;
        entry_o.is_load = writer && isLoad;
        entry_o.is_md   = writer && isAlu && isMulDiv;
    end

endmodule

// File: rtl/status_hazard_unit.sv
// Tracks in-flight rstatus writers through X/M/W and resolves the bex operand:
// forward from the youngest writer, read the regfile, or freeze decode.
module status_hazard_unit
    import status_hazard_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STATUS_REG = STATUS_REG_DEFAULT,
    parameter int DEPTH      = 3   // legal range 1..4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall_in,
    input  logic                    flush,
    input  logic                    fd_valid,
    input  logic [ADDR_W-1:0]       fd_opcode,
    input  logic [ADDR_W-1:0]       fd_aluop,
    input  logic [ADDR_W-1:0]       fd_rd,
    input  logic                    md_done,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    input  logic [DATA_W-1:0]       rf_status,
    output logic                    bex_stall,
    output logic [2:0]              bex_fwd_sel,
    output logic [DATA_W-1:0]       bex_status,
    output logic [2:0]              pending
);

    sb_entry_t sb_q [DEPTH];
    sb_entry_t sb_d [DEPTH];
    sb_entry_t decEntry;

    logic       isBex;
    logic       found;
    logic [2:0] youngIdx;

    status_writer_classify #(
        .ADDR_W     (ADDR_W),
        .STATUS_REG (STATUS_REG)
    ) u_classify (
        .valid_i  (fd_valid),
        .opcode_i (fd_opcode),
        .aluop_i  (fd_aluop),
        .rd_i     (fd_rd),
        .entry_o  (decEntry)
    );

    assign isBex = fd_valid && (fd_opcode == ADDR_W'(OPC_BEX));

    // A global freeze holds the pipe, but a flush still kills whatever sits in X
    always_comb begin
        sb_d = sb_q;
        if (!stall_in) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0] = (bex_stall || flush) ? '0 : decEntry;
        end else if (flush) begin
            sb_d[0] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    // Scanning oldest-to-youngest lets the youngest valid entry win
    always_comb begin
        found    = 1'b0;
        youngIdx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (sb_q[k].valid) begin
                found    = 1'b1;
                youngIdx = 3'(k);
            end
        end
    end

    always_comb begin
        bex_stall   = 1'b0;
        bex_fwd_sel = 3'd0;
        bex_status  = rf_status;
        if (isBex && found) begin
            if (youngIdx == 3'd0 && sb_q[0].is_load) begin
                bex_stall = 1'b1;
            end else if (youngIdx == 3'd0 && sb_q[0].is_md && !md_done) begin
                bex_stall = 1'b1;
            end else begin
                bex_fwd_sel = youngIdx + 3'd1;
                bex_status  = stage_data[int'(youngIdx)*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        pending = 3'd0;
        for (int k = 0; k < DEPTH; k++) begin
            pending = pending + 3'(sb_q[k].valid);
        end
    end

endmodule

// File: tb/tb_status_hazard_unit.sv
// Directed scoreboard bench for status_hazard_unit: the driver queues the
// hand-computed response for every cycle and a monitor checks it mid-cycle.
module tb_status_hazard_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 3;

    localparam logic [4:0] ALU  = 5'b00000;
    localparam logic [4:0] ADDI = 5'b00101;
    localparam logic [4:0] LW   = 5'b01000;
    localparam logic [4:0] SETX = 5'b10101;
    localparam logic [4:0] BEX  = 5'b10110;
    localparam logic [4:0] MUL  = 5'b00110;
    localparam logic [4:0] R30  = 5'd30;
    localparam logic [4:0] R29  = 5'd29;

    localparam logic [DATA_W-1:0] S0 = 32'hAAAA_0000;
    localparam logic [DATA_W-1:0] S1 = 32'hBBBB_1111;
    localparam logic [DATA_W-1:0] S2 = 32'hCCCC_2222;
    localparam logic [DATA_W-1:0] RF = 32'h0000_0042;

    logic                    clock;
    logic                    reset;
    logic                    stall_in;
    logic                    flush;
    logic                    fd_valid;
    logic [ADDR_W-1:0]       fd_opcode;
    logic [ADDR_W-1:0]       fd_aluop;
    logic [ADDR_W-1:0]       fd_rd;
    logic                    md_done;
    logic [DEPTH*DATA_W-1:0] stage_data;
    logic [DATA_W-1:0]       rf_status;
    logic                    bex_stall;
    logic [2:0]              bex_fwd_sel;
    logic [DATA_W-1:0]       bex_status;
    logic [2:0]              pending;

    typedef struct packed {
        int unsigned       id;
        logic              stall;
        logic [2:0]        sel;
        logic [DATA_W-1:0] status;
        logic [2:0]        pend;
    } exp_t;

    exp_t        expQ[$];
    int          testsRun  = 0;
    int          testsFail = 0;
    int unsigned cycleId   = 0;

    status_hazard_unit #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STATUS_REG (30),
        .DEPTH      (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall_in    (stall_in),
        .flush       (flush),
        .fd_valid    (fd_valid),
        .fd_opcode   (fd_opcode),
        .fd_aluop    (fd_aluop),
        .fd_rd       (fd_rd),
        .md_done     (md_done),
        .stage_data  (stage_data),
        .rf_status   (rf_status),
        .bex_stall   (bex_stall),
        .bex_fwd_sel (bex_fwd_sel),
        .bex_status  (bex_status),
        .pending     (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] expectStatus(input logic [2:0] sel);
        case (sel)
            3'd1:    return S0;
            3'd2:    return S1;
            3'd3:    return S2;
            default: return RF;
        endcase
    endfunction

    // One pipeline cycle: drive decode/control inputs just after the edge and
    // queue the response the DUT must show during that same cycle
    task automatic applyStimulus(input logic rst, input logic stl, input logic fl,
                                 input logic v, input logic [4:0] opc,
                                 input logic [4:0] alu, input logic [4:0] rd,
                                 input logic mdd, input logic eStall,
                                 input logic [2:0] eSel, input logic [2:0] ePend);
        exp_t e;
        @(posedge clock);
        #1;
        reset     = rst;
        stall_in  = stl;
        flush     = fl;
        fd_valid  = v;
        fd_opcode = opc;
        fd_aluop  = alu;
        fd_rd     = rd;
        md_done   = mdd;
        e.id      = cycleId;
        e.stall   = eStall;
        e.sel     = eSel;
        e.status  = expectStatus(eSel);
        e.pend    = ePend;
        expQ.push_back(e);
        cycleId++;
    endtask

    task automatic checkOutput(input exp_t e);
        testsRun++;
        if (bex_stall !== e.stall) begin
            testsFail++;
            $display("[TB] FAIL cycle %0d bex_stall: got %0b want %0b", e.id, bex_stall, e.stall);
        end
        testsRun++;
        if (bex_fwd_sel !== e.sel) begin
            testsFail++;
            $display("[TB] FAIL cycle %0d bex_fwd_sel: got %0d want %0d", e.id, bex_fwd_sel, e.sel);
        end
        testsRun++;
        if (bex_status !== e.status) begin
            testsFail++;
            $display("[TB] FAIL cycle %0d bex_status: got %h want %h", e.id, bex_status, e.status);
        end
        testsRun++;
        if (pending !== e.pend) begin
            testsFail++;
            $display("[TB] FAIL cycle %0d pending: got %0d want %0d", e.id, pending, e.pend);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (expQ.size() != 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    initial begin
        reset      = 1'b1;
        stall_in   = 1'b0;
        flush      = 1'b0;
        fd_valid   = 1'b0;
        fd_opcode  = '0;
        fd_aluop   = '0;
        fd_rd      = '0;
        md_done    = 1'b0;
        stage_data = {S2, S1, S0};
        rf_status  = RF;
        repeat (2) @(posedge clock);

        // rst stl fl v opc alu rd mdd | stall sel pend
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd0);   // reset state
        // setx then bex back-to-back: forward from X
        applyStimulus(0,0,0,1,SETX,0  ,0  ,0, 0,3'd0,3'd0);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,0, 0,3'd1,3'd1);
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd0);
        // lw r30 then bex: one load-use stall, then forward from M
        applyStimulus(0,0,0,1,LW  ,0  ,R30,0, 0,3'd0,3'd0);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,0, 1,3'd0,3'd1);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,0, 0,3'd2,3'd1);
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd0);
        // mul r30 then bex: stall while mult/div freezes the pipe
        applyStimulus(0,0,0,1,ALU ,MUL,R30,0, 0,3'd0,3'd0);
        applyStimulus(0,1,0,1,BEX ,0  ,0  ,0, 1,3'd0,3'd1);
        applyStimulus(0,1,0,1,BEX ,0  ,0  ,0, 1,3'd0,3'd1);
        applyStimulus(0,1,0,1,BEX ,0  ,0  ,0, 1,3'd0,3'd1);
        applyStimulus(0,1,0,1,BEX ,0  ,0  ,0, 1,3'd0,3'd1);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,1, 0,3'd1,3'd1);
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd0);
        // addi r30, nop, nop, bex -> W; one extra nop -> regfile
        applyStimulus(0,0,0,1,ADDI,0  ,R30,0, 0,3'd0,3'd0);
        applyStimulus(0,0,0,1,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,0,0,1,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,0, 0,3'd3,3'd1);
        applyStimulus(0,0,0,1,ADDI,0  ,R30,0, 0,3'd0,3'd0);
        applyStimulus(0,0,0,1,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,0,0,1,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,0,0,1,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,0, 0,3'd0,3'd0);
        // flushed setx never enters the scoreboard
        applyStimulus(0,0,1,1,SETX,0  ,0  ,0, 0,3'd0,3'd0);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,0, 0,3'd0,3'd0);
        // freeze for three cycles: writer stays in M
        applyStimulus(0,0,0,1,SETX,0  ,0  ,0, 0,3'd0,3'd0);
        applyStimulus(0,0,0,1,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,1,0,1,BEX ,0  ,0  ,0, 0,3'd2,3'd1);
        applyStimulus(0,1,0,1,BEX ,0  ,0  ,0, 0,3'd2,3'd1);
        applyStimulus(0,1,1,1,BEX ,0  ,0  ,0, 0,3'd2,3'd1);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,0, 0,3'd2,3'd1);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,0, 0,3'd3,3'd1);
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd0);
        // flush during freeze clears X only; older writer holds in M
        applyStimulus(0,0,0,1,SETX,0  ,0  ,0, 0,3'd0,3'd0);
        applyStimulus(0,0,0,1,SETX,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,1,1,0,ALU ,0  ,0  ,0, 0,3'd0,3'd2);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,0, 0,3'd2,3'd1);
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd1);
        applyStimulus(0,0,0,0,ALU ,0  ,0  ,0, 0,3'd0,3'd0);
        // reset in the middle of a mult/div stall
        applyStimulus(0,0,0,1,ALU ,MUL,R30,0, 0,3'd0,3'd0);
        applyStimulus(0,1,0,1,BEX ,0  ,0  ,0, 1,3'd0,3'd1);
        applyStimulus(1,1,0,1,BEX ,0  ,0  ,0, 1,3'd0,3'd1);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,0, 0,3'd0,3'd0);
        // addi r29 is not an rstatus writer
        applyStimulus(0,0,0,1,ADDI,0  ,R29,0, 0,3'd0,3'd0);
        applyStimulus(0,0,0,1,BEX ,0  ,0  ,0, 0,3'd0,3'd0);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
            @(posedge clock);
        end
        if (expQ.size() != 0) begin
            testsRun++;
            testsFail++;
            $display("[TB] FAIL drain: got %0d queued want 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
